// File: rtl/count_sweep_ctrl.sv
// count_sweep_ctrl: sequences an external up/down counter through a preload
// followed by a programmable number of full up/down sweeps, then clears it.
// The counter reports its own boundaries via max_tick/min_tick; this block
// drops en at a boundary so the counter never wraps.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; outputs quiet, sweep_cnt holds result
//   LOAD   | one-cycle load of the latched preload value
//   UP     | counting up until the counter reports all-ones
//   DOWN   | counting down until the counter reports zero
//   CLEAR  | one-cycle synchronous clear of the counter
//   DONE   | one-cycle completion pulse
module count_sweep_ctrl #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pause,
  input  logic [N-1:0] ld_val,
  input  logic [3:0]   sweeps,
  input  logic         max_tick,
  input  logic         min_tick,
  output logic         syn_clr,
  output logic         load,
  output logic         en,
  output logic         up,
  output logic [N-1:0] d,
  output logic         busy,
  output logic         done,
  output logic [3:0]   sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_UP    = 3'd2,
    S_DOWN  = 3'd3,
    S_CLEAR = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [N-1:0] ld_reg;
  logic [3:0]   sweeps_eff;
  logic [3:0]   cnt_inc;
  logic         accept;
  logic         sweep_end;
  logic         last_sweep;

  // A start is only honoured from IDLE; anything arriving while busy is dropped.
  assign accept    = (state == S_IDLE) && start;

  // Only the tick that matches the current direction ends a half-sweep, so a
  // bogus simultaneous max_tick/min_tick cannot confuse the sequence.
  assign sweep_end = (state == S_DOWN) && min_tick;

  // Saturating increment keeps sweep_cnt from wrapping back to zero.
  assign cnt_inc    = (sweep_cnt == 4'hF) ? 4'hF : (sweep_cnt + 4'd1);
  assign last_sweep = (cnt_inc == sweeps_eff);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = S_UP;
      end
      S_UP: begin
        // Leaving on max_tick even when paused: en is already low there.
        if (max_tick) begin
          state_nxt = S_DOWN;
        end
      end
      S_DOWN: begin
        if (min_tick) begin
          state_nxt = last_sweep ? S_CLEAR : S_UP;
        end
      end
      S_CLEAR: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Run configuration captured at start; a zero sweep count means one sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_reg     <= '0;
      sweeps_eff <= 4'd1;
    end else if (accept) begin
      ld_reg     <= ld_val;
      sweeps_eff <= (sweeps == 4'd0) ? 4'd1 : sweeps;
    end
  end

  // Completed-sweep counter: cleared on accepted start, bumped at each bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_cnt <= 4'd0;
    end else if (accept) begin
      sweep_cnt <= 4'd0;
    end else if (sweep_end) begin
      sweep_cnt <= cnt_inc;
    end
  end

  // Output decode; load/syn_clr/en each live in a distinct state so they are
  // mutually exclusive by construction.
  always_comb begin
    syn_clr = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    up      = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        load = 1'b1;
      end
      S_UP: begin
        up = 1'b1;
        en = ~pause & ~max_tick;
      end
      S_DOWN: begin
        en = ~pause & ~min_tick;
      end
      S_CLEAR: begin
        syn_clr = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign d = ld_reg;

endmodule

// File: doc/count_sweep_ctrl.md
COUNT_SWEEP_CTRL -- requirements
Module: count_sweep_ctrl

Interface
REQ-001 Parameter N, default 3, width of the counter value, load value and d bus.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a sweep run; sampled only in IDLE.
REQ-005 pause  input  1  level; holds the counter (en=0) while high, state unchanged.
REQ-006 ld_val  input  N  preload value, latched when start is accepted.
REQ-007 sweeps  input  4  number of up/down sweeps, latched with start; 0 is treated as 1.
REQ-008 max_tick  input  1  counter at all-ones, from the counter.
REQ-009 min_tick  input  1  counter at zero, from the counter.
REQ-010 syn_clr  output  1  synchronous clear command to the counter.
REQ-011 load  output  1  load command to the counter.
REQ-012 en  output  1  count enable to the counter.
REQ-013 up  output  1  count direction to the counter, 1=up.
REQ-014 d  output  N  load data to the counter, equals latched ld_val.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at run completion.
REQ-017 sweep_cnt  output  4  completed sweeps in the current run.

Function
REQ-018 States SHALL be IDLE, LOAD, UP, DOWN, CLEAR, DONE; IDLE waits for start.
REQ-019 IDLE with start=1: next state LOAD; ld_val and sweeps latched; sweep_cnt cleared to 0.
REQ-020 LOAD: load=1, d=latched ld_val for exactly one cycle, next state UP unconditionally.
REQ-021 UP: up=1; en = ~pause & ~max_tick (combinational), so the counter never wraps past all-ones.
REQ-022 UP with max_tick=1: next state DOWN, regardless of pause.
REQ-023 DOWN: up=0; en = ~pause & ~min_tick (combinational), so the counter never wraps below zero.
REQ-024 DOWN with min_tick=1: sweep_cnt increments; next state CLEAR if new sweep_cnt equals effective sweeps, else UP.
REQ-025 CLEAR: syn_clr=1 for exactly one cycle, next state DONE.
REQ-026 DONE: done=1 for exactly one cycle, next state IDLE; sweep_cnt holds final value until next accepted start.
REQ-027 load, syn_clr and en SHALL be mutually exclusive in every cycle.
REQ-028 start while busy SHALL be ignored and not queued; ld_val/sweeps changes while busy SHALL have no effect.
REQ-029 ld_val equal to all-ones: UP sees max_tick immediately, spends one cycle with en=0, then DOWN.
REQ-030 max_tick and min_tick both high (illegal, N mismatch): the tick matching the current state governs; the other is ignored.
REQ-031 sweep_cnt SHALL saturate at 15 and never wrap.

Reset
REQ-032 rst=1 at any time, including mid-run, SHALL force IDLE immediately with syn_clr, load, en, up, busy, done =0, d=0, sweep_cnt=0.
REQ-033 After rst deasserts the block SHALL require a new start; no interrupted run resumes.

Verification
REQ-034 N=3, ld_val=3, sweeps=1, pause=0, start sampled at edge E0 -> LOAD cycle 1, UP cycles 2-6 (en high while q=3..6), DOWN cycles 7-14 (q 7->0), CLEAR cycle 15, done high cycle 16, sweep_cnt=1.
REQ-035 N=3, ld_val=0, sweeps=3 -> three full 0->7->0 sweeps, q never wraps, sweep_cnt steps 1,2,3, single done pulse.
REQ-036 pause high 4 cycles during UP at q=5 -> en=0 and q held at 5 for those 4 cycles, run resumes, done delayed by exactly 4 cycles.
REQ-037 rst pulse during DOWN at q=4 -> all outputs 0 asynchronously, state IDLE, no done; new start runs normally.
REQ-038 start pulsed again in UP, and ld_val changed -> no effect on run; ld_val=7, sweeps=0 run -> one sweep, UP lasts one cycle with en=0, sweep_cnt=1.
